// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//
// Parametrised register file used by the system controller as shared
// configuration and operand storage.
//
// Registers 0-3 are also exported as continuous taps. They feed the ALU
// operands and the UART/clock-divider configuration.
//
// The module has the following features:
//   - a registered read port with a one-cycle valid strobe;
//   - reset defaults for the UART (register 2) and divider (register 3) words;
//   - a per-register write-protect mask;
//   - one-cycle error strobes for out-of-range addresses and protected writes.
//
// Ports:
//   clk           in   system clock, rising edge
//   RST           in   asynchronous reset, active low
//   WrEn          in   write request
//   RdEn          in   read request (WrEn & RdEn together is ignored)
//   Address       in   register index, ADDR_WIDTH bits
//   WrData        in   write data, DATA_WIDTH bits
//   RdData        out  registered read data, holds between reads
//   RdData_Valid  out  one-cycle strobe, RdData was updated
//   AddrErr       out  one-cycle strobe, request to Address >= DEPTH
//   WrProtErr     out  one-cycle strobe, write to a read-only register
//   REG0..REG3    out  continuous copies of registers 0-3
// -----------------------------------------------------------------------------
module reg_file_param #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] REG2_INIT  = 8'h81,
  parameter logic [DATA_WIDTH-1:0] REG3_INIT  = 8'h20,
  parameter logic [DEPTH-1:0]      RO_MASK    = '0
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  WrEn,
  input  logic                  RdEn,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  RdData_Valid,
  output logic                  AddrErr,
  output logic                  WrProtErr,
  output logic [DATA_WIDTH-1:0] REG0,
  output logic [DATA_WIDTH-1:0] REG1,
  output logic [DATA_WIDTH-1:0] REG2,
  output logic [DATA_WIDTH-1:0] REG3
);

  // The storage must reset to per-register defaults asynchronously.
  // For that reason it is built from flops rather than a RAM macro.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_addr_err;
  logic                  r_prot_err;

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic [DEPTH-1:0]      w_sel;
  logic [DEPTH-1:0]      w_wr_mask;
  logic                  w_addr_ok;
  logic                  w_prot_hit;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Reset value of register idx.
  function automatic logic [DATA_WIDTH-1:0] f_reset_value(input int idx);
    logic [DATA_WIDTH-1:0] v;
    case (idx)
      2:       v = REG2_INIT;
      3:       v = REG3_INIT;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Simultaneous read and write is illegal and decodes to "no request".
  assign w_wr_req = WrEn & ~RdEn;
  assign w_rd_req = RdEn & ~WrEn;

  // One-hot decode of the address over the implemented registers only.
  // An out-of-range address selects nothing. Range checking is therefore
  // just "no select bit set", and no array access ever goes past DEPTH.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_decode
      assign w_sel[gi] = (Address == ADDR_WIDTH'(gi));
    end
  endgenerate

  assign w_addr_ok  = |w_sel;
  assign w_prot_hit = |(w_sel & RO_MASK);
  assign w_wr_mask  = w_sel & ~RO_MASK & {DEPTH{w_wr_req}};

  // AND-OR read mux driven by the one-hot select.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rd_word = w_rd_word | (r_mem[i] & {DATA_WIDTH{w_sel[i]}});
    end
  end

  // Register array. Protected registers are never written, so they keep
  // their reset value for life.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= f_reset_value(i);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_mask[i]) begin
          r_mem[i] <= WrData;
        end
      end
    end
  end

  // Read port and status strobes. RdData loads only on an accepted read.
  // Otherwise it holds its last value, including through illegal and
  // out-of-range requests.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_addr_err <= 1'b0;
      r_prot_err <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_req & w_addr_ok;
      r_addr_err <= (w_wr_req | w_rd_req) & ~w_addr_ok;
      r_prot_err <= w_wr_req & w_prot_hit;
      if (w_rd_req && w_addr_ok) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign RdData       = r_rd_data;
  assign RdData_Valid = r_rd_valid;
  assign AddrErr      = r_addr_err;
  assign WrProtErr    = r_prot_err;

  // Taps come straight from the storage, so a write is visible right after
  // the edge that performs it.
  assign REG0 = r_mem[0];
  assign REG1 = r_mem[1];
  assign REG2 = r_mem[2];
  assign REG3 = r_mem[3];

endmodule

// File: tb/tb_reg_file_param.sv
// -----------------------------------------------------------------------------
// tb_reg_file_param
//
// Directed testbench for reg_file_param. The instance is configured with
// DEPTH=12, so addresses 12..15 are out of range. Register 2 is read-only.
// -----------------------------------------------------------------------------
module tb_reg_file_param;

  logic       clk;
  logic       RST;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       AddrErr;
  logic       WrProtErr;
  logic [7:0] REG0;
  logic [7:0] REG1;
  logic [7:0] REG2;
  logic [7:0] REG3;

  int checks = 0;
  int errors = 0;

  reg_file_param #(
    .DATA_WIDTH (8),
    .DEPTH      (12),
    .ADDR_WIDTH (4),
    .REG2_INIT  (8'h81),
    .REG3_INIT  (8'h20),
    .RO_MASK    (12'h004)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .AddrErr      (AddrErr),
    .WrProtErr    (WrProtErr),
    .REG0         (REG0),
    .REG1         (REG1),
    .REG2         (REG2),
    .REG3         (REG3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one request; it is sampled at the next rising edge.
  task automatic drive(input logic wr, input logic rd, input logic [3:0] addr,
                       input logic [7:0] data);
    WrEn    = wr;
    RdEn    = rd;
    Address = addr;
    WrData  = data;
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    #23;
    checks++; if (REG0 !== 8'h00) begin errors++; $display("FAIL reset_reg0 got %h exp %h", REG0, 8'h00); end
    checks++; if (REG1 !== 8'h00) begin errors++; $display("FAIL reset_reg1 got %h exp %h", REG1, 8'h00); end
    checks++; if (REG2 !== 8'h81) begin errors++; $display("FAIL reset_reg2 got %h exp %h", REG2, 8'h81); end
    checks++; if (REG3 !== 8'h20) begin errors++; $display("FAIL reset_reg3 got %h exp %h", REG3, 8'h20); end
    checks++; if (RdData !== 8'h00) begin errors++; $display("FAIL reset_rddata got %h exp %h", RdData, 8'h00); end
    checks++; if ({RdData_Valid, AddrErr, WrProtErr} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp %b", {RdData_Valid, AddrErr, WrProtErr}, 3'b000); end
    @(negedge clk);
    RST = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 4'd5, 8'hA5);
    step();
    checks++; if (RdData_Valid !== 1'b0) begin errors++; $display("FAIL wr_no_valid got %b exp %b", RdData_Valid, 1'b0); end
    drive(1'b0, 1'b1, 4'd5, 8'h00);
    step();
    checks++; if (RdData !== 8'hA5) begin errors++; $display("FAIL rd5_data got %h exp %h", RdData, 8'hA5); end
    checks++; if (RdData_Valid !== 1'b1) begin errors++; $display("FAIL rd5_valid got %b exp %b", RdData_Valid, 1'b1); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    checks++; if (RdData_Valid !== 1'b0) begin errors++; $display("FAIL rd5_valid_drop got %b exp %b", RdData_Valid, 1'b0); end
    checks++; if (RdData !== 8'hA5) begin errors++; $display("FAIL rd5_hold got %h exp %h", RdData, 8'hA5); end
    $display("test_write_read done");
  endtask

  task automatic test_taps();
    drive(1'b1, 1'b0, 4'd0, 8'h3C);
    step();
    checks++; if (REG0 !== 8'h3C) begin errors++; $display("FAIL tap_reg0 got %h exp %h", REG0, 8'h3C); end
    drive(1'b1, 1'b0, 4'd3, 8'h0F);
    step();
    checks++; if (REG3 !== 8'h0F) begin errors++; $display("FAIL tap_reg3 got %h exp %h", REG3, 8'h0F); end
    // Illegal request: both enables together must do nothing.
    drive(1'b1, 1'b1, 4'd3, 8'h55);
    step();
    checks++; if (REG3 !== 8'h0F) begin errors++; $display("FAIL illegal_reg3 got %h exp %h", REG3, 8'h0F); end
    checks++; if (RdData !== 8'hA5) begin errors++; $display("FAIL illegal_rddata got %h exp %h", RdData, 8'hA5); end
    checks++; if ({RdData_Valid, AddrErr, WrProtErr} !== 3'b000) begin errors++; $display("FAIL illegal_strobes got %b exp %b", {RdData_Valid, AddrErr, WrProtErr}, 3'b000); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    $display("test_taps done");
  endtask

  task automatic test_addr_err();
    drive(1'b0, 1'b1, 4'd13, 8'h00);
    step();
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("FAIL rd13_addrerr got %b exp %b", AddrErr, 1'b1); end
    checks++; if (RdData_Valid !== 1'b0) begin errors++; $display("FAIL rd13_valid got %b exp %b", RdData_Valid, 1'b0); end
    checks++; if (RdData !== 8'hA5) begin errors++; $display("FAIL rd13_hold got %h exp %h", RdData, 8'hA5); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    checks++; if (AddrErr !== 1'b0) begin errors++; $display("FAIL addrerr_pulse got %b exp %b", AddrErr, 1'b0); end
    // First out-of-range address, write flavour.
    drive(1'b1, 1'b0, 4'd12, 8'hEE);
    step();
    checks++; if ({AddrErr, WrProtErr} !== 2'b10) begin errors++; $display("FAIL wr12_strobes got %b exp %b", {AddrErr, WrProtErr}, 2'b10); end
    // Last in-range address reads its reset value.
    drive(1'b0, 1'b1, 4'd11, 8'h00);
    step();
    checks++; if ({RdData_Valid, AddrErr} !== 2'b10) begin errors++; $display("FAIL rd11_strobes got %b exp %b", {RdData_Valid, AddrErr}, 2'b10); end
    checks++; if (RdData !== 8'h00) begin errors++; $display("FAIL rd11_data got %h exp %h", RdData, 8'h00); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    $display("test_addr_err done");
  endtask

  task automatic test_write_protect();
    drive(1'b1, 1'b0, 4'd2, 8'hFF);
    step();
    checks++; if ({WrProtErr, AddrErr} !== 2'b10) begin errors++; $display("FAIL wp_strobes got %b exp %b", {WrProtErr, AddrErr}, 2'b10); end
    checks++; if (REG2 !== 8'h81) begin errors++; $display("FAIL wp_reg2 got %h exp %h", REG2, 8'h81); end
    drive(1'b0, 1'b1, 4'd2, 8'h00);
    step();
    checks++; if (RdData !== 8'h81) begin errors++; $display("FAIL wp_read got %h exp %h", RdData, 8'h81); end
    checks++; if ({RdData_Valid, WrProtErr} !== 2'b10) begin errors++; $display("FAIL wp_read_strobes got %b exp %b", {RdData_Valid, WrProtErr}, 2'b10); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    $display("test_write_protect done");
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 4'd6, 8'h5A);
    step();
    drive(1'b0, 1'b1, 4'd6, 8'h00);
    step();
    checks++; if (RdData !== 8'h5A) begin errors++; $display("FAIL raw6_data got %h exp %h", RdData, 8'h5A); end
    drive(1'b0, 1'b1, 4'd0, 8'h00);
    step();
    checks++; if ({RdData_Valid, RdData} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL b2b_rd0 got %b/%h exp 1/3c", RdData_Valid, RdData); end
    drive(1'b0, 1'b1, 4'd3, 8'h00);
    step();
    checks++; if ({RdData_Valid, RdData} !== {1'b1, 8'h0F}) begin errors++; $display("FAIL b2b_rd3 got %b/%h exp 1/0f", RdData_Valid, RdData); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 4'd7, 8'h77);
    step();
    drive(1'b0, 1'b1, 4'd7, 8'h00);
    step();
    checks++; if ({RdData_Valid, RdData} !== {1'b1, 8'h77}) begin errors++; $display("FAIL rd7_pre got %b/%h exp 1/77", RdData_Valid, RdData); end
    // Assert reset between edges; the effect must not wait for clk.
    #2;
    RST = 1'b0;
    #1;
    checks++; if (RdData !== 8'h00) begin errors++; $display("FAIL async_rddata got %h exp %h", RdData, 8'h00); end
    checks++; if (RdData_Valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp %b", RdData_Valid, 1'b0); end
    checks++; if ({REG0, REG3} !== {8'h00, 8'h20}) begin errors++; $display("FAIL async_taps got %h/%h exp 00/20", REG0, REG3); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    RST = 1'b1;
    drive(1'b0, 1'b1, 4'd7, 8'h00);
    step();
    checks++; if ({RdData_Valid, RdData} !== {1'b1, 8'h00}) begin errors++; $display("FAIL rd7_post got %b/%h exp 1/00", RdData_Valid, RdData); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_taps();
    test_addr_err();
    test_write_protect();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised register file; successor to the fixed 8x16 register file. Serves the system controller as shared configuration and operand storage. Adds generic width and depth, a registered read with a one-cycle valid strobe, and reset defaults for the UART and clock-divider configuration words. Adds a per-register write-protect mask, an out-of-range address flag, and dedicated always-visible taps for registers 0–3, which feed ALU operands and UART/divider configuration.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits
- DEPTH, 16, number of registers, 4..2^ADDR_WIDTH
- ADDR_WIDTH, 4, address width; DEPTH ≤ 2^ADDR_WIDTH
- REG2_INIT, 8'h81, reset value of register 2 (UART config: parity enable, prescale 32)
- REG3_INIT, 8'h20, reset value of register 3 (clock divider ratio 32)
- RO_MASK, 0 (DEPTH bits), bit i = 1 makes register i read-only (holds its reset value)

Ports:
- clk  in  1  system clock, rising-edge
- RST  in  1  asynchronous reset, active-low
- WrEn  in  1  write request
- RdEn  in  1  read request
- Address  in  ADDR_WIDTH  register index
- WrData  in  DATA_WIDTH  write data
- RdData  out  DATA_WIDTH  registered read data
- RdData_Valid  out  1  one-cycle strobe, RdData updated
- AddrErr  out  1  one-cycle strobe, request to an out-of-range address
- WrProtErr  out  1  one-cycle strobe, write to a read-only register
- REG0, REG1, REG2, REG3  out  DATA_WIDTH each  continuous copies of registers 0–3

## Operation
- Reset (RST = 0, asynchronous):
  - all registers clear to 0, except register 2 = REG2_INIT and register 3 = REG3_INIT
  - RdData = 0; RdData_Valid, AddrErr and WrProtErr = 0
- Request decode, sampled at the rising edge of clk:
  - WrEn=1, RdEn=0: write request
  - WrEn=0, RdEn=1: read request
  - both 1: illegal; no operation, no strobes, RdData holds
  - both 0: idle
- Write to a valid address (Address < DEPTH):
  - RO_MASK[Address] = 0: register[Address] ← WrData
  - RO_MASK[Address] = 1: register unchanged; WrProtErr pulses
- Read from a valid address: RdData ← register[Address]; RdData_Valid pulses.
- Any request with Address ≥ DEPTH:
  - AddrErr pulses; no register is modified
  - for a read, RdData holds and RdData_Valid stays 0
- RdData holds its last value between reads; it is not cleared when RdEn falls.
- REG0–REG3 are combinational copies of the storage; a write shows on the tap after the same clock edge.
- Back-to-back requests are legal every cycle. A read of an address written in the previous cycle returns the new value.

## Timing
- Write: data is in the array, and on REGn if n ≤ 3, after the rising edge that samples WrEn.
- Read: latency 1 cycle. RdData and RdData_Valid update at the edge that samples RdEn. Valid is high for exactly one cycle per accepted read; a continuous RdEn gives Valid every cycle.
- AddrErr and WrProtErr are high for one cycle after the offending edge.
- Reset mid-operation:
  - outputs and registers go to their reset values immediately, without waiting for clk
  - any request in flight is discarded
  - the first request is accepted at the first rising edge after RST returns high

## Test plan
- Reset: hold RST=0 → REG0=0, REG1=0, REG2=8'h81, REG3=8'h20, RdData=0, all strobes 0.
- Write 8'hA5 to address 5, then read address 5 → RdData=8'hA5 with RdData_Valid high one cycle, one cycle after the RdEn sample edge.
- Write 8'h3C to address 0, then 8'h0F to address 3 → REG0=8'h3C and REG3=8'h0F after the respective edges. Then read address 3 with WrEn=RdEn=1 → no change, no strobes.
- Configure DEPTH=12 and read address 13 → AddrErr pulses once, RdData_Valid=0, RdData keeps its prior value.
- RO_MASK bit 2 set; write 8'hFF to address 2 → WrProtErr pulses; REG2 stays 8'h81; a read of address 2 returns 8'h81.
- Assert RST=0 between two clock edges after writing 8'h77 to address 7 → register 7 and RdData become 0 immediately; a read after release returns 0.
